wire_use: RTL and testbench

//  Registered AND-OR gate: E = (A_i & B_i) | D_i, with the AND term carried on an internal wire C.

---
 rtl/wire_use.sv | 97 +++++++++
 tb/tb_wire_use.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wire_use.sv
// Registered AND-OR gate E = (A & B) | D with optional input register,
// a one-cycle rising-edge pulse on the registered result and a saturating edge counter.
module wire_use #(
    parameter int unsigned CNT_W     = 8,
    parameter bit          INPUT_REG = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             A_i,
    input  logic             B_i,
    input  logic             D_i,
    output logic             E_o,
    output logic             E_comb_o,
    output logic             E_rise_o,
    output logic [CNT_W-1:0] E_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Logic-stage operands: either the raw inputs or their registered copies.
    logic a_s;
    logic b_s;
    logic d_s;

    generate
        if (INPUT_REG) begin : g_in_reg
            logic a_q;
            logic b_q;
            logic d_q;

            // NOTE: sequential state uses non-blocking assignments, and the reset
            // is synchronous, so it lives inside the clocked block, not the sensitivity list.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_q <= 1'b0;
                    b_q <= 1'b0;
                    d_q <= 1'b0;
                end else begin
                    a_q <= A_i;
                    b_q <= B_i;
                    d_q <= D_i;
                end
            end

            assign a_s = a_q;
            assign b_s = b_q;
            assign d_s = d_q;
        end else begin : g_in_direct
            assign a_s = A_i;
            assign b_s = B_i;
            assign d_s = D_i;
        end
    endgenerate

    logic c;
    logic e_next;

    assign c        = a_s & b_s;
    assign e_next   = c | d_s;
    assign E_comb_o = e_next;

    logic             e_q;
    logic             e_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The edge pulse is registered alongside E, so it is high in the very
    // cycle E_o first reads 1; the counter advances on that same edge.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        e_d    = e_next;
        rise_d = e_next & ~e_q;
        cnt_d  = cnt_q;
        if (rise_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e_q    <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            e_q    <= e_d;
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
        end
    end

    assign E_o      = e_q;
    assign E_rise_o = rise_q;
    assign E_cnt_o  = cnt_q;

endmodule

// File: tb/tb_wire_use.sv
// Bench for wire_use: three instances (direct, direct with a 2-bit counter, input-registered)
// share one stimulus stream and are compared against a cycle-level reference model.
module tb_wire_use;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic a;
    logic b;
    logic d;

    logic       e0, ec0, r0;
    logic [7:0] n0;
    logic       es, ecs, rs;
    logic [1:0] ns;
    logic       e1, ec1, r1;
    logic [7:0] n1;

    wire_use #(.CNT_W(8), .INPUT_REG(1'b0)) u_dir (
        .clk_i(clk), .rst_i(rst), .A_i(a), .B_i(b), .D_i(d),
        .E_o(e0), .E_comb_o(ec0), .E_rise_o(r0), .E_cnt_o(n0)
    );

    wire_use #(.CNT_W(2), .INPUT_REG(1'b0)) u_sat (
        .clk_i(clk), .rst_i(rst), .A_i(a), .B_i(b), .D_i(d),
        .E_o(es), .E_comb_o(ecs), .E_rise_o(rs), .E_cnt_o(ns)
    );

    wire_use #(.CNT_W(8), .INPUT_REG(1'b1)) u_reg (
        .clk_i(clk), .rst_i(rst), .A_i(a), .B_i(b), .D_i(d),
        .E_o(e1), .E_comb_o(ec1), .E_rise_o(r1), .E_cnt_o(n1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = u_dir, 1 = u_sat, 2 = u_reg.
    logic       m_e    [3];
    logic       m_rise [3];
    int         m_cnt  [3];
    int         cnt_max[3] = '{255, 3, 255};
    logic [2:0] m_stage;   // inputs as seen by the registered instance, {a,b,d}
    bit         armed = 1'b0;

    function automatic logic gate(input logic [2:0] abd);
        return (abd[2] && abd[1]) || abd[0];
    endfunction

    task automatic drive(input logic [2:0] abd, input logic r);
        {a, b, d} = abd;
        rst       = r;
        #1;
        if (armed) begin
            check("comb_dir", 32'(ec0), 32'(gate(abd)));
            check("comb_sat", 32'(ecs), 32'(gate(abd)));
            check("comb_reg", 32'(ec1), 32'(gate(m_stage)));
        end
    endtask

    task automatic tick();
        logic [2:0] cur;
        logic       r;
        logic       ne;
        logic       nr;
        cur = {a, b, d};
        r   = rst;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            ne = r ? 1'b0 : gate(i == 2 ? m_stage : cur);
            nr = r ? 1'b0 : (ne && !m_e[i]);
            if (r)       m_cnt[i] = 0;
            else if (nr) m_cnt[i] = (m_cnt[i] + 1 > cnt_max[i]) ? cnt_max[i] : m_cnt[i] + 1;
            m_e[i]    = ne;
            m_rise[i] = nr;
        end
        m_stage = r ? 3'b000 : cur;
        if (r) armed = 1'b1;
        if (armed) begin
            check("e_dir",    32'(e0), 32'(m_e[0]));
            check("rise_dir", 32'(r0), 32'(m_rise[0]));
            check("cnt_dir",  32'(n0), 32'(m_cnt[0]));
            check("e_sat",    32'(es), 32'(m_e[1]));
            check("rise_sat", 32'(rs), 32'(m_rise[1]));
            check("cnt_sat",  32'(ns), 32'(m_cnt[1]));
            check("e_reg",    32'(e1), 32'(m_e[2]));
            check("rise_reg", 32'(r1), 32'(m_rise[2]));
            check("cnt_reg",  32'(n1), 32'(m_cnt[2]));
        end
    endtask

    task automatic cycle(input logic [2:0] abd, input logic r);
        drive(abd, r);
        tick();
    endtask

    typedef struct {
        logic [2:0] abd;
        logic       comb;
        logic       rise_first;
        int         cnt_end;
    } vec_t;

    vec_t tt[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tt[0] = '{3'b000, 1'b0, 1'b0, 0};
        tt[1] = '{3'b100, 1'b0, 1'b0, 0};
        tt[2] = '{3'b110, 1'b1, 1'b1, 1};
        tt[3] = '{3'b111, 1'b1, 1'b0, 1};
        tt[4] = '{3'b010, 1'b0, 1'b0, 1};
        tt[5] = '{3'b011, 1'b1, 1'b1, 2};
        tt[6] = '{3'b001, 1'b1, 1'b0, 2};

        for (int i = 0; i < 3; i++) begin
            m_e[i] = 1'b0; m_rise[i] = 1'b0; m_cnt[i] = 0;
        end
        m_stage = 3'b000;

        // Reset state
        cycle(3'b000, 1'b1);
        cycle(3'b000, 1'b1);
        check("reset_e",    32'(e0), 32'd0);
        check("reset_rise", 32'(r0), 32'd0);
        check("reset_cnt",  32'(n0), 32'd0);

        // Truth table and edge count from reset, 5 cycles per pattern
        for (int v = 0; v < 7; v++) begin
            for (int c = 0; c < 5; c++) begin
                drive(tt[v].abd, 1'b0);
                check("tt_comb", 32'(ec0), 32'(tt[v].comb));
                tick();
                check("tt_e", 32'(e0), 32'(tt[v].comb));
                check("tt_rise", 32'(r0), (c == 0) ? 32'(tt[v].rise_first) : 32'd0);
            end
            check("tt_cnt", 32'(n0), 32'(tt[v].cnt_end));
        end

        // Saturation: 10 rises on D
        cycle(3'b000, 1'b1);
        for (int i = 0; i < 20; i++) cycle({2'b00, (i % 2 == 0)}, 1'b0);
        check("sat_cnt2", 32'(ns), 32'd3);
        check("sat_cnt8", 32'(n0), 32'd10);

        // Reset mid-run with E_o=1 and count 2
        cycle(3'b000, 1'b1);
        cycle(3'b001, 1'b0);
        cycle(3'b000, 1'b0);
        cycle(3'b001, 1'b0);
        check("mid_pre_e",   32'(e0), 32'd1);
        check("mid_pre_cnt", 32'(n0), 32'd2);
        drive(3'b001, 1'b1);
        tick();
        check("mid_rst_e",    32'(e0), 32'd0);
        check("mid_rst_cnt",  32'(n0), 32'd0);
        check("mid_rst_rise", 32'(r0), 32'd0);
        drive(3'b001, 1'b0);
        tick();
        check("mid_post_e",    32'(e0), 32'd1);
        check("mid_post_rise", 32'(r0), 32'd1);
        check("mid_post_cnt",  32'(n0), 32'd1);

        // Input-registered latency: 000 -> 110 at cycle t
        cycle(3'b000, 1'b1);
        cycle(3'b000, 1'b0);
        cycle(3'b000, 1'b0);
        drive(3'b110, 1'b0);
        check("ireg_comb_t", 32'(ec1), 32'd0);
        tick();
        check("ireg_e_t1", 32'(e1), 32'd0);
        drive(3'b110, 1'b0);
        check("ireg_comb_t1", 32'(ec1), 32'd1);
        tick();
        check("ireg_e_t2",    32'(e1), 32'd1);
        check("ireg_rise_t2", 32'(r1), 32'd1);
        cycle(3'b110, 1'b0);
        check("ireg_rise_t3", 32'(r1), 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 24) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
